// File: rtl/vending_pkg.sv
// vending_pkg: shared state encoding, credit width helper and no-coin constant
package vending_pkg;

    typedef enum logic [1:0] {IDLE, COLLECT, VEND, REFUND} state_e;

    localparam int NO_COIN = 0;

    // Wide enough for (PRICE-1) + largest coin, the peak credit ever held
    function automatic int credit_width(input int price, input int coin_w);
        return $clog2(price + 2 ** coin_w);
    endfunction

endpackage

// File: rtl/vend_timeout_ctr.sv
// vend_timeout_ctr: inactivity counter with clear/enable, flags the last count before expiry
module vend_timeout_ctr #(
    parameter int MAX = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_o
);

    localparam int W = $clog2(MAX);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb cnt_d = clr_i ? '0 : en_i ? cnt_q + W'(1) : cnt_q;

    always_ff @(posedge clk or negedge rst)
        if (!rst) cnt_q <= '0;
        else      cnt_q <= cnt_d;

    assign expire_o = cnt_q == W'(MAX - 1);

endmodule

// File: rtl/vending_machine_param.sv
// vending_machine_param: coin credit accumulator that vends with change, refunds on cancel or timeout.
// Optional SALES_CNT_EN adds a saturating 16-bit vend counter output sales_cnt.
module vending_machine_param
    import vending_pkg::*;
#(
    parameter int PRICE    = 3,
    parameter int COIN_W   = 2,
    parameter int TIMEOUT  = 16,
    parameter int CREDIT_W = credit_width(PRICE, COIN_W)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [COIN_W-1:0]   coin,
    input  logic                cancel,
    output logic                product,
    output logic                change,
    output logic [CREDIT_W-1:0] change_amt,
    output logic [CREDIT_W-1:0] credit,
    output logic                busy
`ifdef SALES_CNT_EN
    ,
    output logic [15:0]         sales_cnt
`endif
);

    localparam logic [CREDIT_W-1:0] PRICE_C = CREDIT_W'(PRICE);

    state_e state_q, state_d;
    logic [CREDIT_W-1:0] credit_q, credit_d, sum;
    logic coin_v, expire;

    assign coin_v = coin != COIN_W'(NO_COIN);
    assign sum    = credit_q + CREDIT_W'(coin);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (coin_v) state_d = sum >= PRICE_C ? VEND : COLLECT;
            COLLECT: if (cancel) state_d = REFUND;
                     else if (sum >= PRICE_C) state_d = VEND;
                     else if (!coin_v && expire) state_d = REFUND;
            default: state_d = IDLE;
        endcase
    end

    // Busy cycles drop coins; otherwise credit always tracks the running sum
    always_comb credit_d = busy ? '0 : sum;

    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            state_q  <= IDLE;
            credit_q <= '0;
        end else begin
            state_q  <= state_d;
            credit_q <= credit_d;
        end

    vend_timeout_ctr #(.MAX(TIMEOUT)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .clr_i    (state_d != COLLECT || coin_v),
        .en_i     (state_q == COLLECT),
        .expire_o (expire)
    );

    assign product    = state_q == VEND;
    assign busy       = state_q == VEND || state_q == REFUND;
    assign credit     = credit_q;
    assign change_amt = product ? credit_q - PRICE_C : state_q == REFUND ? credit_q : '0;
    assign change     = state_q == REFUND || (product && change_amt != '0);

`ifdef SALES_CNT_EN
    logic [15:0] sales_q, sales_d;

    always_comb sales_d = product && sales_q != 16'hFFFF ? sales_q + 16'd1 : sales_q;

    always_ff @(posedge clk or negedge rst)
        if (!rst) sales_q <= '0;
        else      sales_q <= sales_d;

    assign sales_cnt = sales_q;
`endif

endmodule

// File: tb/tb_vending_machine_param.sv
// tb_vending_machine_param: directed vectors for the default build plus timeout, reset and PRICE=10 sequences
module tb_vending_machine_param;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [1:0] coin = '0;
    logic       cancel = 1'b0;
    logic       product, change, busy;
    logic [2:0] change_amt, credit;

    logic [2:0] coin10 = '0;
    logic       product10, change10, busy10;
    logic [4:0] change_amt10, credit10;

`ifdef SALES_CNT_EN
    logic [15:0] sales, sales10;
`endif

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    vending_machine_param dut (
        .clk        (clk),
        .rst        (rst),
        .coin       (coin),
        .cancel     (cancel),
        .product    (product),
        .change     (change),
        .change_amt (change_amt),
        .credit     (credit),
        .busy       (busy)
`ifdef SALES_CNT_EN
        ,
        .sales_cnt  (sales)
`endif
    );

    vending_machine_param #(.PRICE(10), .COIN_W(3), .TIMEOUT(16)) dut10 (
        .clk        (clk),
        .rst        (rst),
        .coin       (coin10),
        .cancel     (cancel),
        .product    (product10),
        .change     (change10),
        .change_amt (change_amt10),
        .credit     (credit10),
        .busy       (busy10)
`ifdef SALES_CNT_EN
        ,
        .sales_cnt  (sales10)
`endif
    );

    typedef struct {
        logic       rst_n;
        logic [1:0] coin;
        logic       cancel;
        logic       p;
        logic       c;
        logic [2:0] amt;
        logic [2:0] cr;
        logic       b;
    } vec_t;

    vec_t tv[$];

    function automatic void add(logic r, int cn, logic ca, logic p, logic c, int a, int cr, logic b);
        vec_t v;
        v.rst_n = r; v.coin = 2'(cn); v.cancel = ca;
        v.p = p; v.c = c; v.amt = 3'(a); v.cr = 3'(cr); v.b = b;
        tv.push_back(v);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    initial begin
        logic [8:0] act, exp;
        //    rst coin can | p c amt cr b
        add(0, 0, 0,   0, 0, 0, 0, 0);
        add(1, 1, 0,   0, 0, 0, 1, 0);
        add(1, 2, 0,   1, 0, 0, 3, 1);
        add(1, 0, 0,   0, 0, 0, 0, 0);
        add(1, 2, 0,   0, 0, 0, 2, 0);
        add(1, 2, 0,   1, 1, 1, 4, 1);
        add(1, 0, 0,   0, 0, 0, 0, 0);
        add(1, 3, 0,   1, 0, 0, 3, 1);
        add(1, 0, 0,   0, 0, 0, 0, 0);
        add(1, 1, 0,   0, 0, 0, 1, 0);
        add(1, 1, 0,   0, 0, 0, 2, 0);
        add(1, 1, 0,   1, 0, 0, 3, 1);
        add(1, 0, 0,   0, 0, 0, 0, 0);
        add(1, 1, 0,   0, 0, 0, 1, 0);
        add(1, 2, 1,   0, 1, 3, 3, 1);
        add(1, 0, 0,   0, 0, 0, 0, 0);
        add(1, 0, 1,   0, 0, 0, 0, 0);
        add(1, 2, 0,   0, 0, 0, 2, 0);
        add(1, 1, 0,   1, 0, 0, 3, 1);
        add(1, 3, 0,   0, 0, 0, 0, 0);
        add(1, 0, 0,   0, 0, 0, 0, 0);
        add(1, 1, 0,   0, 0, 0, 1, 0);
        add(1, 1, 0,   0, 0, 0, 2, 0);
        add(1, 3, 0,   1, 1, 2, 5, 1);
        add(1, 0, 0,   0, 0, 0, 0, 0);
        add(1, 2, 0,   0, 0, 0, 2, 0);
        add(0, 0, 0,   0, 0, 0, 0, 0);
        add(1, 0, 0,   0, 0, 0, 0, 0);
        add(1, 1, 0,   0, 0, 0, 1, 0);
        add(1, 0, 1,   0, 1, 1, 1, 1);
        add(1, 0, 0,   0, 0, 0, 0, 0);

        foreach (tv[i]) begin
            rst = tv[i].rst_n; coin = tv[i].coin; cancel = tv[i].cancel;
            step();
            act = {product, change, change_amt, credit, busy};
            exp = {tv[i].p, tv[i].c, tv[i].amt, tv[i].cr, tv[i].b};
            n_vec++;
            if (act !== exp) begin
                n_bad++;
                $display("FAIL vec[%0d]: got p/c/amt/cr/b=%b expected %b", i, act, exp);
            end
        end
        coin = 0; cancel = 0;

        // Timeout: refund exactly 16 edges after the coin edge
        coin = 1; step(); coin = 0;
        for (int k = 1; k <= 16; k++) begin
            step();
            if (k < 16) chk($sformatf("to1_wait%0d", k), int'(change), 0);
        end
        chk("to1_change", int'(change), 1);
        chk("to1_amt", int'(change_amt), 1);
        chk("to1_product", int'(product), 0);
        step();
        chk("to1_idle_credit", int'(credit), 0);

        // Timer restarts on a coin at idle cycle 10
        coin = 1; step(); coin = 0;
        for (int k = 1; k <= 9; k++) step();
        coin = 1; step(); coin = 0;
        chk("to2_credit", int'(credit), 2);
        for (int k = 1; k <= 16; k++) begin
            step();
            if (k < 16) chk($sformatf("to2_wait%0d", k), int'(change), 0);
        end
        chk("to2_change", int'(change), 1);
        chk("to2_amt", int'(change_amt), 2);
        step();

        // Asynchronous reset mid-COLLECT
        coin = 2; step(); coin = 0;
        chk("ar_credit_before", int'(credit), 2);
        #2 rst = 0;
        #1 chk("ar_immediate", int'({product, change, change_amt, credit, busy}), 0);
        step();
        rst = 1;
        step();
        chk("ar_no_refund", int'({product, change, change_amt, credit, busy}), 0);

        // PRICE=10, COIN_W=3 overpay
        coin10 = 7; step();
        chk("p10_credit", int'(credit10), 7);
        step(); coin10 = 0;
        chk("p10_product", int'(product10), 1);
        chk("p10_change", int'(change10), 1);
        chk("p10_amt", int'(change_amt10), 4);
        step();
        chk("p10_idle", int'(credit10), 0);

`ifdef SALES_CNT_EN
        rst = 0; step(); rst = 1; step();
        chk("sales_reset", int'(sales10), 0);
        for (int v = 0; v < 3; v++) begin
            coin10 = 7; step(); step(); coin10 = 0; step();
        end
        coin10 = 7; step(); coin10 = 0; cancel = 1; step(); cancel = 0;
        chk("sales_refund_pulse", int'(change_amt10), 7);
        step();
        chk("sales_cnt", int'(sales10), 3);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
